ahb_chan_decoder: RTL

Parametrised AHB-Lite slave decoder for the endpoint data path. It splits the slave address space into per-channel FIFO data windows and one byte-addressable register window. It stalls the bus with wait states until the target channel can accept or supply data, issues the full two-cycle AHB ERROR response, and aborts stalled transfers on a timeout. It sits between the AHB slave port and the channel FIFOs and the status/control register file.

---
 rtl/ahb_dec_pkg.sv | 33 +++
 rtl/ahb_wait_timer.sv | 37 +++
 rtl/ahb_chan_decoder.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/ahb_dec_pkg.sv
// Shared types and constants for the AHB-Lite channel decoder.
// Transfer encodings, decoder states and the size-to-lane mask helper.
package ahb_dec_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'd0;
    localparam logic [1:0] HTRANS_BUSY   = 2'd1;
    localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
    localparam logic [1:0] HTRANS_SEQ    = 2'd3;

    localparam logic [1:0] HSIZE_BYTE = 2'd0;
    localparam logic [1:0] HSIZE_HALF = 2'd1;
    localparam logic [1:0] HSIZE_WORD = 2'd2;
    localparam logic [1:0] HSIZE_ILL  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_ERR1,
        S_ERR2
    } state_e;

    function automatic logic [15:0] size_mask(input logic [1:0] sz);
        logic [15:0] m;
        unique case (sz)
            HSIZE_BYTE: m = 16'h0001;
            HSIZE_HALF: m = 16'h0003;
            HSIZE_WORD: m = 16'h000F;
            default:    m = 16'h0000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/ahb_wait_timer.sv
// Wait-state counter: clears on clr, counts while en, flags the
// cycle in which the count reaches MAX_WAIT.
module ahb_wait_timer #(
    parameter int MAX_WAIT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic timeout
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX_WAIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        timeout = en && (cnt_q == LAST);
        cnt_d   = cnt_q;
        if (clr || timeout) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ahb_chan_decoder.sv
// AHB-Lite slave decoder: per-channel FIFO data windows plus a
// byte-addressable register window, with wait states and timeout errors.
module ahb_chan_decoder
    import ahb_dec_pkg::*;
#(
    parameter int          ADDR_W   = 8,
    parameter int          NUM_CH   = 2,
    parameter int          MAX_WAIT = 15,
    parameter logic [15:0] WR_MASK  = 16'h0100
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hsel,
    input  logic [ADDR_W-1:0] haddr,
    input  logic [1:0]        htrans,
    input  logic [1:0]        hsize,
    input  logic              hwrite,
    output logic              hready,
    output logic              hresp,
    input  logic [NUM_CH-1:0] ch_rx_valid,
    input  logic [NUM_CH-1:0] ch_tx_ready,
    output logic [NUM_CH-1:0] get_rx_data,
    output logic [NUM_CH-1:0] store_tx_data,
    output logic              reg_rd,
    output logic              reg_wr,
    output logic [15:0]       reg_be
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    state_e            state_q, state_d;
    logic              is_reg_q, is_reg_d;
    logic              write_q, write_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [15:0]       be_q, be_d;

    logic              accept;
    logic              a_is_reg;
    logic [CH_W-1:0]   a_ch;
    logic [15:0]       a_be;
    logic              a_err;
    logic              ch_ok;
    logic              done;
    logic              wait_en;
    logic              wait_clr;
    logic              timeout;

    // Address-phase decode, used only when the transfer is accepted.
    always_comb begin
        a_is_reg = haddr[ADDR_W-1];
        a_ch     = (NUM_CH > 1) ? haddr[ADDR_W-2 -: CH_W] : '0;
        a_be     = size_mask(hsize) << haddr[3:0];
        a_err    = (hsize == HSIZE_ILL)
                || ((hsize == HSIZE_HALF) && haddr[0])
                || ((hsize == HSIZE_WORD) && (haddr[1:0] != 2'b00))
                || (a_is_reg && (haddr[ADDR_W-2:4] != '0))
                || (a_is_reg && hwrite && ((a_be & ~WR_MASK) != 16'h0000));
    end

    always_comb begin
        ch_ok = write_q ? ch_tx_ready[ch_q] : ch_rx_valid[ch_q];
    end

    always_comb begin
        state_d       = state_q;
        is_reg_d      = is_reg_q;
        write_d       = write_q;
        ch_d          = ch_q;
        be_d          = be_q;
        hready        = 1'b1;
        hresp         = 1'b0;
        get_rx_data   = '0;
        store_tx_data = '0;
        reg_rd        = 1'b0;
        reg_wr        = 1'b0;
        reg_be        = 16'h0000;
        done          = 1'b0;
        wait_en       = 1'b0;

        unique case (state_q)
            S_IDLE: begin
            end
            S_DATA: begin
                if (is_reg_q || ch_ok) begin
                    done    = 1'b1;
                    state_d = S_IDLE;
                    if (is_reg_q) begin
                        reg_rd = !write_q;
                        reg_wr = write_q;
                        reg_be = be_q;
                    end else if (write_q) begin
                        store_tx_data = NUM_CH'(1) << ch_q;
                    end else begin
                        get_rx_data = NUM_CH'(1) << ch_q;
                    end
                end else begin
                    hready  = 1'b0;
                    wait_en = 1'b1;
                    if (timeout) begin
                        state_d = S_ERR1;
                    end
                end
            end
            S_ERR1: begin
                hready  = 1'b0;
                hresp   = 1'b1;
                state_d = S_ERR2;
            end
            S_ERR2: begin
                hresp   = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        accept = hsel && hready
              && ((htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ));

        // A new address phase overlaps any completing data phase.
        if (accept) begin
            state_d  = a_err ? S_ERR1 : S_DATA;
            is_reg_d = a_is_reg;
            write_d  = hwrite;
            ch_d     = a_ch;
            be_d     = a_be;
        end

        wait_clr = !wait_en;
    end

    ahb_wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (wait_clr),
        .en      (wait_en),
        .timeout (timeout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            is_reg_q <= 1'b0;
            write_q  <= 1'b0;
            ch_q     <= '0;
            be_q     <= 16'h0000;
        end else begin
            state_q  <= state_d;
            is_reg_q <= is_reg_d;
            write_q  <= write_d;
            ch_q     <= ch_d;
            be_q     <= be_d;
        end
    end

endmodule
